// File: rtl/sseg_scan_decoder_pkg.sv
// rtl/sseg_scan_decoder_pkg.sv - seven-segment glyph table and pattern-to-hex decode helper
package sseg_scan_decoder_pkg;

  typedef logic [6:0] glyph_t;

  // Segment order {g,f,e,d,c,b,a}; must match the display driver's encoder table.
  localparam glyph_t SEG_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic void seg_to_hex(input glyph_t p, output logic legal, output logic [3:0] h);
    legal = 1'b0;
    h     = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (p == SEG_GLYPH[i]) begin
        legal = 1'b1;
        h     = 4'(i);
      end
    end
  endfunction

endpackage

// File: rtl/sseg_scan_decoder_if.sv
// rtl/sseg_scan_decoder_if.sv - multiplexed display bus: active-low anodes plus {dp,g..a} segments
interface sseg_scan_decoder_if #(
  parameter int N_DIGITS = 4
);
  logic [N_DIGITS-1:0] an;
  logic [7:0]          sseg;

  modport master (output an, sseg);
  modport slave  (input  an, sseg);
endinterface

// File: rtl/sseg_scan_decoder_digit_tracker.sv
// rtl/sseg_scan_decoder_digit_tracker.sv - per-digit readback state with staleness timeout
module sseg_digit_tracker #(
  parameter int TIMEOUT_CYC = 2**18
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       accept,
  input  logic       legal,
  input  logic [3:0] value,
  input  logic       dp_in,
  output logic [3:0] hex,
  output logic       dp,
  output logic       valid,
  output logic       err
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] tcnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tcnt  <= '0;
      hex   <= 4'h0;
      dp    <= 1'b0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else if (accept) begin
      tcnt <= '0;
      if (legal) begin
        hex   <= value;
        dp    <= dp_in;
        valid <= 1'b1;
        err   <= 1'b0;
      end else begin
        valid <= 1'b0;
        err   <= 1'b1;
      end
    end else if (tcnt == TMAX) begin
      // Saturated: the digit stays stale until the next accept.
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

endmodule

// File: rtl/sseg_scan_decoder.sv
// rtl/sseg_scan_decoder.sv - snoops a multiplexed seven-segment bus and rebuilds each digit's value
module sseg_scan_decoder
  import sseg_scan_decoder_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int STABLE_CYC  = 8,
  parameter int TIMEOUT_CYC = 2**18
) (
  input  logic                        clk,
  input  logic                        reset_n,
  sseg_scan_decoder_if.slave          bus,
  output logic [4*N_DIGITS-1:0]       hex_out,
  output logic [N_DIGITS-1:0]         dp_out,
  output logic [N_DIGITS-1:0]         valid,
  output logic [N_DIGITS-1:0]         err,
  output logic                        upd,
  output logic [$clog2(N_DIGITS)-1:0] upd_idx
);
  localparam int IW = $clog2(N_DIGITS);
  localparam int SW = $clog2(STABLE_CYC);
  localparam logic [SW-1:0] SMAX = SW'(STABLE_CYC - 1);

  logic [N_DIGITS-1:0] an_q, an_p;
  logic [7:0]          sseg_q, sseg_p;
  logic [SW-1:0]       stab_cnt;
  logic                committed;

  logic                sel_ok;
  logic [IW-1:0]       sel_idx;
  logic                clr;
  logic                accept;
  logic                legal;
  logic [3:0]          value;
  int                  zeros;

  // an_p/sseg_p is the sample the stability count refers to, so it is the
  // value decoded once the count says the dwell has settled.
  always_comb begin
    zeros   = 0;
    sel_idx = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (!an_p[i]) begin
        zeros   = zeros + 1;
        sel_idx = IW'(i);
      end
    end
    sel_ok = (zeros == 1);
    clr    = !sel_ok || (an_q != an_p) || (sseg_q != sseg_p);
    accept = sel_ok && (stab_cnt == SMAX) && !committed;
    seg_to_hex(sseg_p[6:0], legal, value);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      an_q      <= '0;
      an_p      <= '0;
      sseg_q    <= 8'h00;
      sseg_p    <= 8'h00;
      stab_cnt  <= '0;
      committed <= 1'b0;
      upd       <= 1'b0;
      upd_idx   <= '0;
    end else begin
      an_q   <= bus.an;
      an_p   <= an_q;
      sseg_q <= bus.sseg;
      sseg_p <= sseg_q;
      if (clr) begin
        stab_cnt  <= '0;
        committed <= 1'b0;
      end else begin
        if (stab_cnt != SMAX) stab_cnt <= stab_cnt + 1'b1;
        if (accept) committed <= 1'b1;
      end
      upd <= accept;
      if (accept) upd_idx <= sel_idx;
    end
  end

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
    sseg_digit_tracker #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_trk (
      .clk     (clk),
      .reset_n (reset_n),
      .accept  (accept && (sel_idx == IW'(g))),
      .legal   (legal),
      .value   (value),
      .dp_in   (sseg_p[7]),
      .hex     (hex_out[4*g +: 4]),
      .dp      (dp_out[g]),
      .valid   (valid[g]),
      .err     (err[g])
    );
  end

endmodule
